// File: rtl/spike_aer_encoder.sv
// Spike-to-AER encoder: queues spike events and end-of-timestep markers
// in a first-word-fall-through FIFO, and tracks the timestep, dropped spikes and overflow.
module spike_aer_encoder #(
    parameter int unsigned NR_DEPTH   = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TS_WIDTH   = 8,
    localparam int unsigned AW = $clog2(NR_DEPTH),
    localparam int unsigned DW = 1 + TS_WIDTH + AW,
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                freeze,
    input  logic                spike_valid,
    input  logic                spike_out,
    input  logic [AW-1:0]       spike_addr,
    input  logic                step_done,
    output logic                aer_valid,
    input  logic                aer_ready,
    output logic [DW-1:0]       aer_data,
    output logic [TS_WIDTH-1:0] ts_now,
    output logic [CW-1:0]       fifo_count,
    output logic [7:0]          drop_count,
    output logic                overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [DW-1:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                marker_pending;
    logic [TS_WIDTH-1:0] marker_ts;

    logic          spike_req_c;
    logic          step_c;
    logic          pop_c;
    logic          room_c;
    logic          wr_spike_c;
    logic          wr_marker_c;
    logic          wr_c;
    logic          drop_c;
    logic          collide_c;
    logic [DW-1:0] wdata_c;

    assign aer_valid = (fifo_count != '0);
    assign aer_data  = mem[rd_ptr];

    // Write arbitration: a spike wins over a pending marker; a full queue only accepts when popping
    always_comb begin
        spike_req_c = spike_valid & spike_out & ~freeze;
        step_c      = step_done & ~freeze;
        pop_c       = aer_valid & aer_ready;
        room_c      = (fifo_count != CW'(FIFO_DEPTH)) | pop_c;
        wr_spike_c  = spike_req_c & room_c;
        wr_marker_c = marker_pending & ~spike_req_c & room_c;
        wr_c        = wr_spike_c | wr_marker_c;
        drop_c      = spike_req_c & ~room_c;
        collide_c   = step_c & marker_pending & ~wr_marker_c;
        wdata_c     = wr_spike_c ? {1'b0, ts_now, spike_addr}
                                 : {1'b1, marker_ts, {AW{1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_c) begin
            mem[wr_ptr] <= wdata_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            ts_now         <= '0;
            drop_count     <= '0;
            overflow       <= 1'b0;
            marker_pending <= 1'b0;
            marker_ts      <= '0;
        end else begin
            if (wr_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_c, pop_c})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (wr_marker_c) begin
                marker_pending <= 1'b0;
            end
            // A new marker is only captured if the slot is free or being freed this cycle
            if (step_c) begin
                ts_now <= ts_now + TS_WIDTH'(1);
                if (!marker_pending || wr_marker_c) begin
                    marker_pending <= 1'b1;
                    marker_ts      <= ts_now;
                end
            end

            if (drop_c && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
            if (drop_c || collide_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed testbench for spike_aer_encoder with default parameters.
module tb_spike_aer_encoder;

    logic        clk;
    logic        reset;
    logic        freeze;
    logic        spike_valid;
    logic        spike_out;
    logic [3:0]  spike_addr;
    logic        step_done;
    logic        aer_valid;
    logic        aer_ready;
    logic [12:0] aer_data;
    logic [7:0]  ts_now;
    logic [3:0]  fifo_count;
    logic [7:0]  drop_count;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    logic [12:0] got [$];

    spike_aer_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .freeze     (freeze),
        .spike_valid(spike_valid),
        .spike_out  (spike_out),
        .spike_addr (spike_addr),
        .step_done  (step_done),
        .aer_valid  (aer_valid),
        .aer_ready  (aer_ready),
        .aer_data   (aer_data),
        .ts_now     (ts_now),
        .fifo_count (fifo_count),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted event mid-cycle, away from the sampling edge
    always @(negedge clk) begin
        if (!reset && aer_valid && aer_ready) got.push_back(aer_data);
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        freeze = 1'b0; spike_valid = 1'b0; spike_out = 1'b0;
        spike_addr = 4'd0; step_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        aer_ready = 1'b0;
        cyc(2);
        reset = 1'b0;
        got.delete();
    endtask

    task automatic spike(input logic [3:0] a);
        spike_valid = 1'b1; spike_out = 1'b1; spike_addr = a;
        cyc();
        spike_valid = 1'b0; spike_out = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", aer_valid); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if (ts_now !== 8'd0) begin errors++; $display("FAIL reset_ts got=%0d exp=0", ts_now); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    endtask

    task automatic test_basic();
        logic [12:0] exp [3];
        logic [12:0] v;
        exp = '{13'h003, 13'h007, 13'h1000};
        do_reset();
        aer_ready = 1'b1;
        spike(4'd3);
        spike(4'd7);
        step_done = 1'b1; cyc(); step_done = 1'b0;
        cyc(5);
        checks++; if (got.size() != 3) begin errors++; $display("FAIL basic_n got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            v = (i < got.size()) ? got[i] : 13'bx;
            checks++; if (v !== exp[i]) begin errors++; $display("FAIL basic_ev%0d got=%h exp=%h", i, v, exp[i]); end
        end
        checks++; if (ts_now !== 8'd1) begin errors++; $display("FAIL basic_ts got=%0d exp=1", ts_now); end
    endtask

    task automatic test_overflow();
        logic [12:0] v;
        do_reset();
        for (int i = 1; i <= 10; i++) spike(4'(i));
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
        checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL ovf_drop got=%0d exp=2", drop_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        aer_ready = 1'b1;
        cyc(10);
        checks++; if (got.size() != 8) begin errors++; $display("FAIL ovf_n got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            v = (i < got.size()) ? got[i] : 13'bx;
            checks++; if (v !== 13'(i + 1)) begin errors++; $display("FAIL ovf_ev%0d got=%h exp=%h", i, v, 13'(i + 1)); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    endtask

    task automatic test_full_pop();
        logic [12:0] v;
        do_reset();
        for (int i = 0; i < 8; i++) spike(4'(i));
        aer_ready = 1'b1;
        spike(4'd15);
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fullpop_count got=%0d exp=8", fifo_count); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL fullpop_drop got=%0d exp=0", drop_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_flag got=%0b exp=0", overflow); end
        cyc(10);
        checks++; if (got.size() != 9) begin errors++; $display("FAIL fullpop_n got=%0d exp=9", got.size()); end
        v = (got.size() > 8) ? got[8] : 13'bx;
        checks++; if (v !== 13'h00F) begin errors++; $display("FAIL fullpop_last got=%h exp=00f", v); end
    endtask

    task automatic test_same_cycle();
        logic [12:0] v0, v1;
        do_reset();
        aer_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step_done = 1'b1; cyc(); step_done = 1'b0; cyc();
        end
        cyc(3);
        got.delete();
        spike_valid = 1'b1; spike_out = 1'b1; spike_addr = 4'd9; step_done = 1'b1;
        cyc();
        idle_inputs();
        cyc(5);
        v0 = (got.size() > 0) ? got[0] : 13'bx;
        v1 = (got.size() > 1) ? got[1] : 13'bx;
        checks++; if (got.size() != 2) begin errors++; $display("FAIL same_n got=%0d exp=2", got.size()); end
        checks++; if (v0 !== 13'h0059) begin errors++; $display("FAIL same_spike got=%h exp=0059", v0); end
        checks++; if (v1 !== 13'h1050) begin errors++; $display("FAIL same_marker got=%h exp=1050", v1); end
        checks++; if (ts_now !== 8'd6) begin errors++; $display("FAIL same_ts got=%0d exp=6", ts_now); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL same_flag got=%0b exp=0", overflow); end
    endtask

    task automatic test_collision();
        logic [12:0] v0, v1;
        do_reset();
        step_done = 1'b1; cyc();
        spike_valid = 1'b1; spike_out = 1'b1; spike_addr = 4'd2;
        cyc();
        idle_inputs();
        cyc();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL coll_flag got=%0b exp=1", overflow); end
        checks++; if (ts_now !== 8'd2) begin errors++; $display("FAIL coll_ts got=%0d exp=2", ts_now); end
        aer_ready = 1'b1;
        cyc(5);
        v0 = (got.size() > 0) ? got[0] : 13'bx;
        v1 = (got.size() > 1) ? got[1] : 13'bx;
        checks++; if (got.size() != 2) begin errors++; $display("FAIL coll_n got=%0d exp=2", got.size()); end
        checks++; if (v0 !== 13'h0012) begin errors++; $display("FAIL coll_spike got=%h exp=0012", v0); end
        checks++; if (v1 !== 13'h1000) begin errors++; $display("FAIL coll_marker got=%h exp=1000", v1); end
    endtask

    task automatic test_freeze();
        logic [12:0] v;
        do_reset();
        for (int i = 1; i <= 3; i++) spike(4'(i));
        freeze = 1'b1;
        spike_valid = 1'b1; spike_out = 1'b1; spike_addr = 4'd12; step_done = 1'b1;
        cyc();
        checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL frz_count got=%0d exp=3", fifo_count); end
        aer_ready = 1'b1;
        cyc(5);
        checks++; if (ts_now !== 8'd0) begin errors++; $display("FAIL frz_ts got=%0d exp=0", ts_now); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL frz_drain got=%0d exp=0", fifo_count); end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL frz_n got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            v = (i < got.size()) ? got[i] : 13'bx;
            checks++; if (v !== 13'(i + 1)) begin errors++; $display("FAIL frz_ev%0d got=%h exp=%h", i, v, 13'(i + 1)); end
        end
        idle_inputs();
        cyc(2);
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL frz_nomarker got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        aer_ready = 1'b1;
        step_done = 1'b1; cyc(); step_done = 1'b0;
        cyc(3);
        aer_ready = 1'b0;
        for (int i = 0; i < 4; i++) spike(4'(i + 4));
        checks++; if (fifo_count !== 4'd4 || aer_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got=%0d/%0b exp=4/1", fifo_count, aer_valid); end
        checks++; if (ts_now !== 8'd1) begin errors++; $display("FAIL mid_pre_ts got=%0d exp=1", ts_now); end
        reset = 1'b1; aer_ready = 1'b1;
        spike_valid = 1'b1; spike_out = 1'b1; spike_addr = 4'd1; step_done = 1'b1;
        cyc();
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%0b exp=0", aer_valid); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
        checks++; if (ts_now !== 8'd0) begin errors++; $display("FAIL mid_ts got=%0d exp=0", ts_now); end
        reset = 1'b0;
        idle_inputs();
        cyc(2);
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL mid_nomarker got=%0d exp=0", fifo_count); end
    endtask

    initial begin
        reset = 1'b1;
        aer_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_same_cycle();
        test_collision();
        test_freeze();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_aer_encoder.md
SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 SHALL have parameter NR_DEPTH, default 16, number of neurons; AW = $clog2(NR_DEPTH).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, event queue entries (power of 2, >=2).
REQ-003 SHALL have parameter TS_WIDTH, default 8, timestep counter width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port freeze  input  1  high: spike inputs and step_done ignored.
REQ-007 SHALL have port spike_valid  input  1  neuron-update result valid this cycle.
REQ-008 SHALL have port spike_out  input  1  neuron fired (qualified by spike_valid).
REQ-009 SHALL have port spike_addr  input  AW  index of neuron just updated.
REQ-010 SHALL have port step_done  input  1  one-cycle pulse, last neuron of timestep updated.
REQ-011 SHALL have port aer_valid  output  1  event available.
REQ-012 SHALL have port aer_ready  input  1  consumer accepts event.
REQ-013 SHALL have port aer_data  output  1+TS_WIDTH+AW  {type, ts, addr}; type 0 = spike, 1 = end-of-step marker.
REQ-014 SHALL have port ts_now  output  TS_WIDTH  current timestep.
REQ-015 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held.
REQ-016 SHALL have port drop_count  output  8  spikes dropped, saturating at 255.
REQ-017 SHALL have port overflow  output  1  sticky error flag.

Function
REQ-018 SHALL generate a spike write request when spike_valid & spike_out & ~freeze, with data {0, ts_now, spike_addr}.
REQ-019 SHALL, on step_done & ~freeze, load a marker-pending register with {1, ts_now, 0} and increment ts_now (modulo 2^TS_WIDTH, 255->0 for default width) in the same cycle.
REQ-020 SHALL perform at most one queue write per cycle; priority: spike request over pending marker.
REQ-021 SHALL write the pending marker in the first cycle with no spike request and queue not full (or popping); pending clears on that write.
REQ-022 SHALL, if step_done arrives while a marker is still pending, keep the older marker, discard the new one, still increment ts_now, and set overflow.
REQ-023 SHALL accept a write when fifo_count < FIFO_DEPTH, or when full and a pop occurs in the same cycle.
REQ-024 SHALL drop a spike request that cannot be written (full, no pop), increment drop_count (saturating), and set overflow; markers are never dropped by fullness, only held pending.
REQ-025 SHALL present first-word-fall-through output: aer_valid = (fifo_count != 0), aer_data = oldest entry, combinationally from storage.
REQ-026 SHALL pop on aer_valid & aer_ready; aer_data and aer_valid SHALL hold stable while aer_valid & ~aer_ready.
REQ-027 SHALL make a written entry visible on aer_valid the cycle after the write (latency 1); fifo_count updates same edge.
REQ-028 SHALL adjust fifo_count by +1 on write only, -1 on pop only, 0 on simultaneous write and pop.
REQ-029 SHALL wrap read/write pointers modulo FIFO_DEPTH.
REQ-030 SHALL keep draining (pops honoured) while freeze is high; ts_now, drop_count unchanged by ignored inputs.
REQ-031 SHALL preserve event order: output order equals acceptance order.
REQ-032 SHALL treat spike_valid with spike_out=0 as no request.

Reset
REQ-033 SHALL, on clk edge with reset high: pointers=0, fifo_count=0, aer_valid=0, ts_now=0, drop_count=0, overflow=0, marker pending cleared; storage contents need not reset.
REQ-034 SHALL abandon any in-flight pop or write in a reset cycle; reset has priority over all inputs.
REQ-035 SHALL clear overflow only by reset.

Verification
REQ-036 SHALL cover: reset, spikes at addr 3,7 in ts 0, step_done, aer_ready=1 -> outputs {0,0,3},{0,0,7},{1,0,0}; ts_now=1.
REQ-037 SHALL cover: aer_ready=0, 10 spikes with FIFO_DEPTH=8 -> fifo_count=8, drop_count=2, overflow=1, first 8 addrs preserved in order.
REQ-038 SHALL cover: full queue, aer_ready=1 and spike same cycle -> spike accepted, fifo_count stays 8, drop_count unchanged.
REQ-039 SHALL cover: spike_valid&spike_out and step_done same cycle at ts 5 -> spike {0,5,a} emitted before marker {1,5,0}; ts_now=6.
REQ-040 SHALL cover: freeze=1 with spikes and step_done -> no writes, ts_now unchanged, queued events still drain.
REQ-041 SHALL cover: reset asserted with 4 queued events and aer_valid=1 -> next cycle aer_valid=0, fifo_count=0, ts_now=0.
